// File: rtl/ntt_ram_sched_pkg.sv
// Shared widths, FSM encoding and delay-line entry layout for the NTT coefficient RAM scheduler.
package ntt_pkg;
  localparam int AWID   = 8;
  localparam int N      = 1 << AWID;
  localparam int STAGES = AWID;
  localparam int CW     = AWID - 2;  // N/4 read cycles per stage, two butterflies each

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic            vld;
    logic [AWID-1:0] a1;
    logic [AWID-1:0] b1;
    logic [AWID-1:0] a2;
    logic [AWID-1:0] b2;
  } ent_t;
endpackage

// File: rtl/ntt_ram_sched_if.sv
// RAM-side bundle of the scheduler: shared port addresses, write enable and butterfly input strobes.
interface ntt_ram_if;
  import ntt_pkg::*;

  logic [AWID-1:0] A1radd;
  logic [AWID-1:0] B1radd;
  logic [AWID-1:0] A2radd;
  logic [AWID-1:0] B2radd;
  logic            we;
  logic            rd_valid;
  logic [AWID-2:0] tw1;
  logic [AWID-2:0] tw2;

  modport master (output A1radd, B1radd, A2radd, B2radd, we, rd_valid, tw1, tw2);
  modport slave  (input  A1radd, B1radd, A2radd, B2radd, we, rd_valid, tw1, tw2);
endinterface

// File: rtl/ntt_ram_sched_bf_addr.sv
// Combinational radix-2 butterfly address map: (stage, butterfly index) -> (a, b, twiddle exponent).
module ntt_bf_addr
  import ntt_pkg::*;
(
  input  logic [AWID-1:0] stg,
  input  logic [AWID-2:0] j,
  output logic [AWID-1:0] a,
  output logic [AWID-1:0] b,
  output logic [AWID-2:0] tw
);
  logic [AWID-1:0] half;
  logic [AWID-1:0] mask;
  logic [AWID-1:0] jw;
  logic [AWID-1:0] pos;

  // half is a power of two, so j/half and j%half reduce to masking
  always_comb begin
    half = AWID'(N / 2) >> stg;
    mask = half - AWID'(1);
    jw   = {1'b0, j};
    pos  = jw & mask;
    a    = ((jw & ~mask) << 1) | pos;
    b    = a + half;
    tw   = (AWID-1)'(pos << stg);
  end
endmodule

// File: rtl/ntt_ram_sched.sv
// In-place NTT stage scheduler: two butterflies per read slot, write-back BF_LAT+1 cycles later on the
// same addresses; write slots always win over reads and each stage drains before the next one reads.
module ntt_ram_sched
  import ntt_pkg::*;
#(
  parameter int BF_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AWID-1:0] stage,
  ntt_ram_if.master       ram
);
  localparam logic [CW-1:0] C_LAST = CW'(N / 4 - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [AWID-1:0] stage_q, stage_d;
  ent_t            dl [0:BF_LAT];
  logic            rd_valid_q;
  logic [AWID-2:0] tw1_q, tw2_q;

  logic [AWID-1:0] g_a1, g_b1, g_a2, g_b2;
  logic [AWID-2:0] g_tw1, g_tw2;
  logic            write_due, rd_issue, dl_empty;

  ntt_bf_addr u_bf1 (.stg(stage_q), .j({c_q, 1'b0}), .a(g_a1), .b(g_b1), .tw(g_tw1));
  ntt_bf_addr u_bf2 (.stg(stage_q), .j({c_q, 1'b1}), .a(g_a2), .b(g_b2), .tw(g_tw2));

  // The tail entry is being written this cycle, so only the upstream entries gate the stage fence
  always_comb begin
    write_due = dl[BF_LAT].vld;
    rd_issue  = (state_q == S_READ) && !write_due;
    dl_empty  = 1'b1;
    for (int i = 0; i < BF_LAT; i++) begin
      if (dl[i].vld) dl_empty = 1'b0;
    end
  end

  always_comb begin
    ram.we     = 1'b0;
    ram.A1radd = '0;
    ram.B1radd = '0;
    ram.A2radd = '0;
    ram.B2radd = '0;
    if (write_due) begin
      ram.we     = 1'b1;
      ram.A1radd = dl[BF_LAT].a1;
      ram.B1radd = dl[BF_LAT].b1;
      ram.A2radd = dl[BF_LAT].a2;
      ram.B2radd = dl[BF_LAT].b2;
    end else if (rd_issue) begin
      ram.A1radd = g_a1;
      ram.B1radd = g_b1;
      ram.A2radd = g_a2;
      ram.B2radd = g_b2;
    end
  end

  assign ram.rd_valid = rd_valid_q;
  assign ram.tw1      = tw1_q;
  assign ram.tw2      = tw2_q;
  assign busy         = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign stage        = stage_q;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          c_d     = '0;
          stage_d = '0;
        end
      end
      S_READ: begin
        if (rd_issue) begin
          c_d = c_q + CW'(1);
          if (c_q == C_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dl_empty) begin
          if (stage_q == AWID'(STAGES - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            c_d     = '0;
            stage_d = stage_q + AWID'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      stage_q    <= '0;
      rd_valid_q <= 1'b0;
      tw1_q      <= '0;
      tw2_q      <= '0;
      for (int i = 0; i <= BF_LAT; i++) dl[i] <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      stage_q    <= stage_d;
      rd_valid_q <= rd_issue;
      tw1_q      <= rd_issue ? g_tw1 : '0;
      tw2_q      <= rd_issue ? g_tw2 : '0;
      dl[0]      <= '{vld: rd_issue, a1: g_a1, b1: g_b1, a2: g_a2, b2: g_b2};
      for (int i = 1; i <= BF_LAT; i++) dl[i] <= dl[i-1];
    end
  end
endmodule
